// File: rtl/maxnet_pkg.sv
// Shared definitions for the 4-neuron Maxnet winner-take-all controller:
// FSM state encoding, neuron count, index width and a popcount helper.
package maxnet_pkg;

  localparam int NUM_NEURONS = 4;
  localparam int IDX_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EVAL = 3'd2,
    ST_ITER = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/maxnet_onehot_index.sv
// Combinational summary of the neuron "value > 0" vector: population count,
// lowest set index (0 when empty) and a single-survivor flag.
module maxnet_onehot_index
  import maxnet_pkg::*;
(
  input  logic [NUM_NEURONS-1:0] vec,
  output logic [2:0]             pc,
  output logic [IDX_W-1:0]       low_idx,
  output logic                   single
);

  assign pc     = popcount4(vec);
  assign single = (pc == 3'd1);

  // Priority encoder: lowest set bit wins, empty vector maps to index 0.
  always_comb begin
    low_idx = 2'd0;
    casez (vec)
      4'b???1: low_idx = 2'd0;
      4'b??10: low_idx = 2'd1;
      4'b?100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the Maxnet datapath: load, iterate inhibition until at
// most one neuron survives. Optional iteration limit via MAXNET_TIMEOUT_EN.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] nonzero,
  output logic                   ld_init,
  output logic                   ld_iter,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic                   no_winner,
  output logic                   timeout,
  output logic [CNT_W-1:0]       iter_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_r;
  logic             ld_init_r;
  logic             ld_iter_r;
  logic             busy_r;
  logic             done_r;
  logic [IDX_W-1:0] winner_r;
  logic             no_winner_r;
  logic [CNT_W-1:0] iter_count_r;
  logic [2:0]       pc_s;
  logic [IDX_W-1:0] low_idx_s;
  logic             single_s;
  logic             settled_s;

  maxnet_onehot_index u_onehot (
    .vec     (nonzero),
    .pc      (pc_s),
    .low_idx (low_idx_s),
    .single  (single_s)
  );

  assign settled_s = single_s || (pc_s == 3'd0);

`ifdef MAXNET_TIMEOUT_EN
  logic timeout_r;
  logic limit_s;

  assign limit_s = (iter_count_r == CNT_W'(MAX_ITER));

  // Timeout flag: cleared on run acceptance, set when the limit ends a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_r <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      timeout_r <= 1'b0;
    end else if (state_r == ST_EVAL && !settled_s && limit_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign timeout = timeout_r;
`else
  logic limit_s;

  assign limit_s = 1'b0;
  assign timeout = 1'b0;
`endif

  // Main FSM; all control pulses and results are registered on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ld_init_r    <= 1'b0;
      ld_iter_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      winner_r     <= 2'd0;
      no_winner_r  <= 1'b0;
      iter_count_r <= '0;
    end else begin
      ld_init_r <= 1'b0;
      ld_iter_r <= 1'b0;
      done_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_LOAD;
            ld_init_r    <= 1'b1;
            busy_r       <= 1'b1;
            winner_r     <= 2'd0;
            no_winner_r  <= 1'b0;
            iter_count_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: state_r <= ST_EVAL;
        ST_EVAL: begin
          if (settled_s) begin
            state_r     <= ST_DONE;
            done_r      <= 1'b1;
            winner_r    <= low_idx_s;
            no_winner_r <= (pc_s == 3'd0);
          end else if (limit_s) begin
            state_r  <= ST_DONE;
            done_r   <= 1'b1;
            winner_r <= low_idx_s;
          end else begin
            // ld_iter is the ITER-state pulse; the count tracks pulses issued.
            state_r   <= ST_ITER;
            ld_iter_r <= 1'b1;
            if (iter_count_r != CNT_MAX) begin
              iter_count_r <= iter_count_r + CNT_W'(1);
            end else begin
              iter_count_r <= iter_count_r;
            end
          end
        end
        ST_ITER: state_r <= ST_EVAL;
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_init    = ld_init_r;
  assign ld_iter    = ld_iter_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign winner     = winner_r;
  assign no_winner  = no_winner_r;
  assign iter_count = iter_count_r;

endmodule
